// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state type, width defaults and port indices for the
// two-client cellular-RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 23;
  localparam int unsigned DATA_W_DEFAULT = 16;

  // Port indices as stored in the arbiter's owner register.
  localparam logic P_AUDIO  = 1'b0;
  localparam logic P_LOADER = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbState_t;

endpackage

// File: rtl/ram_arb_watchdog.sv
// ram_arb_watchdog: BUSY-cycle counter for the RAM arbiter. Cleared when a
// transaction starts, counts while the arbiter is busy, and flags expiry in
// the LIMIT-th busy cycle so the abort lands one cycle later.
module ram_arb_watchdog
  import ram_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] busyCnt;

  // Count busy cycles from zero, holding once the last value is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      busyCnt <= '0;
    end else if (load) begin
      busyCnt <= '0;
    end else if (run && (busyCnt != LAST)) begin
      busyCnt <= busyCnt + 8'd1;
    end
  end

  assign expire = run && (busyCnt == LAST);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single cellular-RAM controller between the audio
// fetch (port 0, priority) and the sample loader / debug port (port 1).
// One transaction in flight at a time; port 1 is guaranteed a grant after
// STARVE_LIMIT consecutive port-0 grants while it waits.
// Optional watchdog abort is compiled in with RAM_ARB_TIMEOUT_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [1:0]        c0_be,
  output logic              c0_gnt,
  output logic              c0_done,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_err,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  input  logic [1:0]        c1_be,
  output logic              c1_gnt,
  output logic              c1_done,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arbState_t  state;
  logic       owner;
  logic [3:0] starveCnt;
  logic       startTxn;
  logic       pickLoader;

  assign startTxn   = (state == IDLE) && (c0_req || c1_req);
  // Loader wins when it is alone, or when it has waited out the starve limit.
  assign pickLoader = c1_req && (!c0_req || (starveCnt == STARVE_MAX));

`ifdef RAM_ARB_TIMEOUT_EN
  logic timeoutHit;

  ram_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (startTxn),
    .run    (state == BUSY),
    .expire (timeoutHit)
  );
`else
  logic [31:0] unusedTimeoutCfg;
  assign unusedTimeoutCfg = TIMEOUT_CYCLES;
  assign c0_err = 1'b0;
  assign c1_err = 1'b0;
`endif

  // Arbitration FSM: latch the winner's fields on grant, return the result
  // to the owner on completion (or abort), all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= P_AUDIO;
      starveCnt <= '0;
      c0_gnt    <= 1'b0;
      c1_gnt    <= 1'b0;
      c0_done   <= 1'b0;
      c1_done   <= 1'b0;
      c0_rdata  <= '0;
      c1_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
      c0_err    <= 1'b0;
      c1_err    <= 1'b0;
`endif
    end else begin
      c0_gnt  <= 1'b0;
      c1_gnt  <= 1'b0;
      c0_done <= 1'b0;
      c1_done <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      c0_err  <= 1'b0;
      c1_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (startTxn) begin
            if (pickLoader) begin
              owner     <= P_LOADER;
              c1_gnt    <= 1'b1;
              mem_we    <= c1_we;
              mem_addr  <= c1_addr;
              mem_wdata <= c1_wdata;
              mem_be    <= c1_be;
              starveCnt <= '0;
            end else begin
              owner     <= P_AUDIO;
              c0_gnt    <= 1'b1;
              mem_we    <= c0_we;
              mem_addr  <= c0_addr;
              mem_wdata <= c0_wdata;
              mem_be    <= c0_be;
              if (c1_req && (starveCnt != STARVE_MAX)) begin
                starveCnt <= starveCnt + 4'd1;
              end
            end
            mem_req <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_done) begin
            if (owner == P_LOADER) begin
              c1_done  <= 1'b1;
              c1_rdata <= mem_we ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
              c0_done  <= 1'b1;
              c0_rdata <= mem_we ? {DATA_W{1'b0}} : mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= IDLE;
          end
`ifdef RAM_ARB_TIMEOUT_EN
          else if (timeoutHit) begin
            if (owner == P_LOADER) begin
              c1_done  <= 1'b1;
              c1_err   <= 1'b1;
              c1_rdata <= '0;
            end else begin
              c0_done  <= 1'b1;
              c0_err   <= 1'b1;
              c0_rdata <= '0;
            end
            mem_req <= 1'b0;
            state   <= IDLE;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-client arbiter sharing the single cellular-RAM controller in the synthesizer top level. It serves two requesters:

- Port 0: audio sample playback fetch. High priority.
- Port 1: sample loader / debug access.

It issues one 16-bit transaction at a time to the memory controller's request/done interface. Fixed priority to port 0, with a starvation limit that guarantees port 1 progress.

## Interface
- ADDR_W, 23: word address width (matches RAM address bus).
- DATA_W, 16: data word width.
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while port 1 waits (1..15).
- TIMEOUT_CYCLES, 255: watchdog limit in BUSY cycles (only with RAM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- cN_req  in  1  (N=0,1) request; addr/we/wdata/be stable while high.
- cN_we  in  1  1=write, 0=read.
- cN_addr  in  ADDR_W  word address.
- cN_wdata  in  DATA_W  write data.
- cN_be  in  2  byte enables {UB,LB}.
- cN_gnt  out  1  one-cycle pulse: request latched.
- cN_done  out  1  one-cycle pulse: transaction complete; cN_rdata valid this cycle.
- cN_rdata  out  DATA_W  read data (0 for writes).
- cN_err  out  1  qualifies cN_done: transaction aborted by watchdog.
- mem_req  out  1  held high for the whole transaction.
- mem_we, mem_addr[ADDR_W], mem_wdata[DATA_W], mem_be[2]  out  latched transaction fields.
- mem_done  in  1  controller completion pulse; mem_rdata valid same cycle.
- mem_rdata  in  DATA_W  controller read data.

## Operation
- FSM states: IDLE, BUSY.
- IDLE, no req: stay.
- IDLE, any req: choose winner, latch fields into mem_* regs, set owner, pulse cN_gnt, assert mem_req, go BUSY.
- Winner selection:
  - Port 0 wins, unless c1_req=1 and starve_cnt==STARVE_LIMIT, in which case port 1 wins.
  - starve_cnt increments (saturating) on each port-0 grant while c1_req=1.
  - starve_cnt clears on any port-1 grant.
- BUSY: requests ignored; mem_* fields frozen.
- BUSY, mem_done=1: capture mem_rdata (0 if write) into owner's rdata, pulse owner's done (err=0), deassert mem_req, go IDLE.
- Clients may hold req through gnt cycle. A req still high when the arbiter returns to IDLE is a new request.
- Reset outputs: all gnt/done/err/mem_req/mem_we = 0, mem_addr/mem_wdata/mem_be/rdata = 0, state IDLE, starve_cnt = 0.
- Reset mid-BUSY drops the transaction; no done is issued.

## Timing
- Request sampled in IDLE at edge T. At T+1: gnt=1 and mem_req=1.
- mem_done sampled at edge D. At D+1: cN_done=1, rdata valid, mem_req=0, state IDLE.
- Earliest next grant: gnt at D+2. Minimum 2-cycle gap between a done and the next gnt.
- Controller must tolerate mem_req still high in the cycle it asserts mem_done.
- mem_done while IDLE: ignored.

## Configuration
- RAM_ARB_TIMEOUT_EN defined:
  - 8-bit BUSY-cycle counter, cleared on entry to BUSY.
  - On reaching TIMEOUT_CYCLES without mem_done: deassert mem_req, pulse owner's done with err=1 and rdata=0, go IDLE.
  - mem_done in the same cycle as expiry wins (err=0).
- Undefined: no counter; err outputs tied 0; BUSY waits indefinitely for mem_done.

## Structure
- Shared package ram_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - ADDR_W/DATA_W defaults;
  - the port index constants P_AUDIO=0, P_LOADER=1.
- One natural sub-module, ram_arb_watchdog: load/count/expire counter, instantiated only under RAM_ARB_TIMEOUT_EN.
- Everything else stays in ram_arbiter.

## Test plan
- Single read: c0 read addr 0x000010, mem_done after 5 cycles with mem_rdata=0xBEEF -> c0_gnt at T+1, c0_done with c0_rdata=0xBEEF one cycle after mem_done, mem_req high exactly 6 cycles.
- Write: c1 write addr 0x7FFFFF data 0x1234 be=2'b01 -> mem_addr=0x7FFFFF, mem_wdata=0x1234, mem_be=01, mem_we=1; c1_done with rdata=0.
- Simultaneous req: both held continuously, mem_done after 3 cycles each -> grant order 0,0,0,0,1,0,0,0,0,1 (STARVE_LIMIT=4).
- Reset mid-BUSY: rst at cycle 3 of a transaction, then mem_done -> no done pulse, all outputs 0, next request granted normally.
- Timeout (macro on, TIMEOUT_CYCLES=10): mem_done never arrives -> c0_done with c0_err=1 and mem_req low at cycle 11 of BUSY. Case with mem_done at expiry cycle -> err=0.
- Back-to-back: c0 req held high after done -> second gnt exactly 2 cycles after first done.
